// File: rtl/pwm_fade_sequencer.sv
// Breathing-LED duty sequencer for a pwm8b: ramp up, hold high, ramp down, hold low,
// once or looped, with every step paced by a programmable prescaler tick.
module pwm_fade_sequencer #(
  parameter int STEP  = 1,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [DIV_W-1:0] step_div,
  input  logic [7:0]       duty_min,
  input  logic [7:0]       duty_max,
  input  logic [7:0]       hold_cnt,
  output logic [7:0]       duty,
  output logic             pwm_en,
  output logic             busy,
  output logic             cycle_done,
  output logic             cfg_err
);

  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_HOLD_HIGH,
    S_RAMP_DOWN,
    S_HOLD_LOW
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       duty_q, duty_d;
  logic             pwm_en_q, pwm_en_d;
  logic             busy_q, busy_d;
  logic             cycle_done_q, cycle_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [7:0]       hold_ctr_q, hold_ctr_d;
  logic             loop_l_q, loop_l_d;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic [7:0]       min_l_q, min_l_d;
  logic [7:0]       max_l_q, max_l_d;
  logic [7:0]       hold_l_q, hold_l_d;

  logic             tick;
  logic [8:0]       up_sum;
  logic [8:0]       dn_diff;
  logic [8:0]       dn_floor;

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    pwm_en_d     = pwm_en_q;
    cycle_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    presc_d      = presc_q;
    hold_ctr_d   = hold_ctr_q;
    loop_l_d     = loop_l_q;
    div_l_d      = div_l_q;
    min_l_d      = min_l_q;
    max_l_d      = max_l_q;
    hold_l_d     = hold_l_q;

    // 9-bit sums keep saturation decisions free of 8-bit wrap-around.
    up_sum   = {1'b0, duty_q} + STEP9;
    dn_diff  = {1'b0, duty_q} - STEP9;
    dn_floor = {1'b0, min_l_q} + STEP9;

    tick = (state_q != S_IDLE) && (presc_q == div_l_q);
    if (state_q != S_IDLE) begin
      presc_d = tick ? '0 : presc_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (duty_min > duty_max) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d    = S_RAMP_UP;
            duty_d     = duty_min;
            pwm_en_d   = 1'b1;
            presc_d    = '0;
            hold_ctr_d = '0;
            loop_l_d   = loop;
            div_l_d    = step_div;
            min_l_d    = duty_min;
            max_l_d    = duty_max;
            hold_l_d   = hold_cnt;
          end
        end
      end
      S_RAMP_UP: begin
        if (tick) begin
          if (up_sum >= {1'b0, max_l_q}) begin
            duty_d     = max_l_q;
            hold_ctr_d = '0;
            state_d    = S_HOLD_HIGH;
          end else begin
            duty_d = up_sum[7:0];
          end
        end
      end
      S_HOLD_HIGH: begin
        if (tick) begin
          if (hold_ctr_q == hold_l_q) state_d = S_RAMP_DOWN;
          else                        hold_ctr_d = hold_ctr_q + 8'd1;
        end
      end
      S_RAMP_DOWN: begin
        if (tick) begin
          if ({1'b0, duty_q} < dn_floor) begin
            duty_d     = min_l_q;
            hold_ctr_d = '0;
            state_d    = S_HOLD_LOW;
          end else begin
            duty_d = dn_diff[7:0];
          end
        end
      end
      S_HOLD_LOW: begin
        if (tick) begin
          if (hold_ctr_q == hold_l_q) begin
            cycle_done_d = 1'b1;
            hold_ctr_d   = '0;
            if (loop_l_q) begin
              state_d = S_RAMP_UP;
            end else begin
              state_d  = S_IDLE;
              duty_d   = '0;
              pwm_en_d = 1'b0;
              presc_d  = '0;
            end
          end else begin
            hold_ctr_d = hold_ctr_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the profile would have done this cycle.
    if (stop && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      duty_d       = '0;
      pwm_en_d     = 1'b0;
      presc_d      = '0;
      hold_ctr_d   = '0;
      cycle_done_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      duty_q       <= '0;
      pwm_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      cycle_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      presc_q      <= '0;
      hold_ctr_q   <= '0;
      loop_l_q     <= 1'b0;
      div_l_q      <= '0;
      min_l_q      <= '0;
      max_l_q      <= '0;
      hold_l_q     <= '0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      pwm_en_q     <= pwm_en_d;
      busy_q       <= busy_d;
      cycle_done_q <= cycle_done_d;
      cfg_err_q    <= cfg_err_d;
      presc_q      <= presc_d;
      hold_ctr_q   <= hold_ctr_d;
      loop_l_q     <= loop_l_d;
      div_l_q      <= div_l_d;
      min_l_q      <= min_l_d;
      max_l_q      <= max_l_d;
      hold_l_q     <= hold_l_d;
    end
  end

  assign duty       = duty_q;
  assign pwm_en     = pwm_en_q;
  assign busy       = busy_q;
  assign cycle_done = cycle_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: STEP=1 and STEP=4 instances share stimulus and are
// compared against a tick-level profile model expanded per clock cycle.
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, loop_i;
  logic [15:0] step_div;
  logic [7:0]  duty_min, duty_max, hold_cnt;
  logic [7:0]  duty_a, duty_b;
  logic        en_a, en_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

  always #5 clk = ~clk;

  pwm_fade_sequencer #(.STEP(1), .DIV_W(16)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop_i),
    .step_div(step_div), .duty_min(duty_min), .duty_max(duty_max), .hold_cnt(hold_cnt),
    .duty(duty_a), .pwm_en(en_a), .busy(busy_a), .cycle_done(done_a), .cfg_err(err_a)
  );

  pwm_fade_sequencer #(.STEP(4), .DIV_W(16)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop_i),
    .step_div(step_div), .duty_min(duty_min), .duty_max(duty_max), .hold_cnt(hold_cnt),
    .duty(duty_b), .pwm_en(en_b), .busy(busy_b), .cycle_done(done_b), .cfg_err(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int m_step, m_min, m_max, m_hold, m_div;
  bit m_loop;
  int tick_q[$];

  // Duty value after each tick of one full profile; the last entry ends the profile.
  function automatic void build_profile();
    int d;
    bit sat;
    tick_q.delete();
    d = m_min;
    do begin
      sat = (d + m_step >= m_max);
      d = sat ? m_max : d + m_step;
      tick_q.push_back(d);
    end while (!sat);
    repeat (m_hold + 1) tick_q.push_back(d);
    do begin
      sat = (d < m_min + m_step);
      d = sat ? m_min : d - m_step;
      tick_q.push_back(d);
    end while (!sat);
    repeat (m_hold + 1) tick_q.push_back(d);
  endfunction

  // Expected {duty, pwm_en, busy, cycle_done, cfg_err} k cycles after the start edge.
  function automatic logic [11:0] expect_at(int k);
    int per, n, len, idx, ed;
    bit act, dn;
    per = m_div + 1;
    n   = k / per;
    len = tick_q.size();
    if (n == 0) begin
      ed = m_min; act = 1'b1; dn = 1'b0;
    end else if (!m_loop && n >= len) begin
      ed = 0; act = 1'b0; dn = (n == len) && (k % per == 0);
    end else begin
      idx = (n - 1) % len;
      ed  = tick_q[idx];
      act = 1'b1;
      dn  = (k % per == 0) && (idx == len - 1);
    end
    return {8'(ed), act, act, dn, 1'b0};
  endfunction

  function automatic logic [11:0] observe(int which);
    if (which == 4) return {duty_b, en_b, busy_b, done_b, err_b};
    return {duty_a, en_a, busy_a, done_a, err_a};
  endfunction

  task automatic start_profile(input int step, input bit lp, input int dv, input int mn,
                               input int mx, input int hd);
    m_step = step; m_loop = lp; m_div = dv; m_min = mn; m_max = mx; m_hold = hd;
    build_profile();
    @(negedge clk);
    loop_i = lp; step_div = 16'(dv); duty_min = 8'(mn); duty_max = 8'(mx);
    hold_cnt = 8'(hd); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic scramble_inputs();
    loop_i   = 1'($urandom);
    step_div = 16'($urandom);
    duty_min = 8'($urandom);
    duty_max = 8'($urandom);
    hold_cnt = 8'($urandom);
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got, exp;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_i = 1'b0;
    step_div = '0; duty_min = '0; duty_max = '0; hold_cnt = '0;
    repeat (2) @(negedge clk);
    for (int w = 1; w <= 4; w += 3) begin
      got = observe(w); n_checks++;
      if (got !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_state s%0d got=%b want=%b", w, got, 12'h000);
      end
    end
    rst_n = 1'b1;
    start_profile(1, 1'b0, 0, 50, 200, 0);
    repeat (3) @(negedge clk);
    got = observe(1); exp = expect_at(3); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_preramp got=%b want=%b", got, exp);
    end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    for (int w = 1; w <= 4; w += 3) begin
      got = observe(w); n_checks++;
      if (got !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_async s%0d got=%b want=%b", w, got, 12'h000);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got = observe(1); n_checks++;
      if (got !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got=%b want=%b", k, got, 12'h000);
      end
    end
  endtask

  task automatic test_one_shot();
    int exp_d[11] = '{10, 11, 12, 13, 13, 13, 12, 11, 10, 10, 10};
    logic [10:0] got, exp;
    start_profile(1, 1'b0, 0, 10, 13, 1);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) @(negedge clk);
      got = {duty_a, en_a, busy_a, done_a};
      if (k < 11)       exp = {8'(exp_d[k]), 3'b110};
      else if (k == 11) exp = {8'd0, 3'b001};
      else              exp = {8'd0, 3'b000};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL one_shot k=%0d got duty=%0d en/busy/done=%b want duty=%0d en/busy/done=%b",
                 k, got[10:3], got[2:0], exp[10:3], exp[2:0]);
      end
    end
    pulse_stop();
  endtask

  task automatic test_saturation();
    int up_d[3] = '{250, 254, 255};
    int dn_d[4] = '{0, 3, 3, 0};
    logic [11:0] got, exp;
    start_profile(4, 1'b0, 0, 250, 255, 0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      got = observe(4); exp = expect_at(k); n_checks++;
      if (k < 3 && exp[11:4] !== 8'(up_d[k])) exp[11:4] = 8'(up_d[k]);
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sat_up k=%0d got duty=%0d flags=%b want duty=%0d flags=%b",
                 k, got[11:4], got[3:0], exp[11:4], exp[3:0]);
      end
      scramble_inputs();
    end
    pulse_stop();
    start_profile(4, 1'b0, 0, 0, 3, 0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      got = observe(4); exp = expect_at(k); n_checks++;
      if (k < 4 && exp[11:4] !== 8'(dn_d[k])) exp[11:4] = 8'(dn_d[k]);
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sat_down k=%0d got duty=%0d flags=%b want duty=%0d flags=%b",
                 k, got[11:4], got[3:0], exp[11:4], exp[3:0]);
      end
    end
    pulse_stop();
  endtask

  task automatic test_prescaler_loop();
    logic [11:0] got, exp;
    start_profile(1, 1'b1, 3, 0, 2, 0);
    for (int k = 0; k < 70; k++) begin
      if (k > 0) @(negedge clk);
      got = observe(1); exp = expect_at(k); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL presc_loop k=%0d got duty=%0d flags=%b want duty=%0d flags=%b",
                 k, got[11:4], got[3:0], exp[11:4], exp[3:0]);
      end
      if (k == 10) begin
        duty_max = 8'd200; duty_min = 8'd1; step_div = 16'd0; hold_cnt = 8'd9; loop_i = 1'b0;
      end
    end
    pulse_stop();
  endtask

  task automatic test_reject_override();
    logic [11:0] got, exp;
    @(negedge clk); duty_min = 8'd20; duty_max = 8'd10; loop_i = 1'b0; step_div = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if ({busy_a, err_a, busy_b, err_b} !== 4'b0101) begin
      n_fail++;
      $display("FAIL reject_pulse got busy/err=%b want %b", {busy_a, err_a, busy_b, err_b}, 4'b0101);
    end
    @(negedge clk);
    n_checks++;
    if ({busy_a, err_a, busy_b, err_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reject_after got busy/err=%b want %b", {busy_a, err_a, busy_b, err_b}, 4'b0000);
    end
    duty_min = 8'd5; duty_max = 8'd9; start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got = observe(1); n_checks++;
      if (got !== 12'h000 || observe(4) !== 12'h000) begin
        n_fail++;
        $display("FAIL start_stop_idle k=%0d got=%b want=%b", k, got, 12'h000);
      end
      @(negedge clk);
    end
    start_profile(1, 1'b0, 0, 0, 2, 5);
    repeat (4) @(negedge clk);
    got = observe(1); exp = expect_at(4); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL hold_high_reach got=%b want=%b", got, exp);
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = observe(1); n_checks++;
      if (got !== 12'h000) begin
        n_fail++;
        $display("FAIL stop_hold_high k=%0d got=%b want=%b", k, got, 12'h000);
      end
      @(negedge clk);
    end
    start_profile(1, 1'b0, 0, 10, 13, 1);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      got = observe(1); exp = expect_at(k); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL start_busy k=%0d got duty=%0d flags=%b want duty=%0d flags=%b",
                 k, got[11:4], got[3:0], exp[11:4], exp[3:0]);
      end
      if (k == 2) begin start = 1'b1; duty_min = 8'd100; duty_max = 8'd120; end
      if (k == 3) start = 1'b0;
    end
    pulse_stop();
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    int w, mn, mx, n;
    for (int it = 0; it < 8; it++) begin
      w  = ($urandom_range(0, 1) == 1) ? 4 : 1;
      mn = int'($urandom_range(0, 255));
      mx = mn + int'($urandom_range(0, 30));
      if (mx > 255) mx = 255;
      start_profile(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), mn, mx,
                    int'($urandom_range(0, 3)));
      n = m_loop ? 120 : (m_div + 1) * tick_q.size() + 3;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        got = observe(w); exp = expect_at(k); n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random it=%0d s%0d k=%0d got duty=%0d flags=%b want duty=%0d flags=%b",
                   it, w, k, got[11:4], got[3:0], exp[11:4], exp[3:0]);
        end
        scramble_inputs();
      end
      pulse_stop();
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_saturation();
    test_prescaler_loop();
    test_reject_override();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
